// File: rtl/fib_arbiter.sv
// Round-robin arbiter that shares one Fibonacci engine among NCLI clients.
// A zero operand is answered locally; every other operand goes through one engine handshake.
module fib_arbiter #(
    parameter int NCLI  = 4,
    parameter int N_IN  = 7,
    parameter int N_OUT = 90,
    localparam int GW   = (NCLI > 1) ? $clog2(NCLI) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCLI-1:0]        cli_req,
    input  logic [NCLI*N_IN-1:0]   cli_n,
    output logic [NCLI-1:0]        cli_ack,
    output logic [N_OUT-1:0]       cli_result,
    output logic                   eng_req,
    output logic [N_IN-1:0]        eng_n,
    input  logic                   eng_ack,
    input  logic [N_OUT-1:0]       eng_result,
    output logic                   busy,
    output logic [GW-1:0]          grant
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [GW-1:0]    ptr, ptr_nxt, grant_nxt, grant_inc, sel;
    logic             sel_valid;
    logic [GW:0]      rr_idx;
    logic [N_IN-1:0]  n_reg, n_reg_nxt, eng_n_nxt;
    logic [N_IN-1:0]  operand [NCLI];
    logic             eng_req_nxt, eng_ack_d, ack_rise;
    logic [NCLI-1:0]  cli_ack_nxt;
    logic [N_OUT-1:0] cli_result_nxt;

    for (genvar g = 0; g < NCLI; g++) begin : g_operand
        assign operand[g] = cli_n[g*N_IN +: N_IN];
    end

    // Completion is the rising edge only: the engine keeps eng_ack high until it sees the next request.
    assign ack_rise  = eng_ack & ~eng_ack_d;
    assign grant_inc = (grant == GW'(NCLI - 1)) ? '0 : grant + GW'(1);

    // Round-robin pick: walk offsets downward so the one closest to ptr wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        rr_idx    = '0;
        for (int i = NCLI - 1; i >= 0; i--) begin
            rr_idx = {1'b0, ptr} + (GW+1)'(i);
            if (rr_idx >= (GW+1)'(NCLI)) rr_idx = rr_idx - (GW+1)'(NCLI);
            if (cli_req[rr_idx[GW-1:0]]) begin
                sel       = rr_idx[GW-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latches).
        state_nxt      = state;
        ptr_nxt        = ptr;
        grant_nxt      = grant;
        n_reg_nxt      = n_reg;
        eng_req_nxt    = eng_req;
        eng_n_nxt      = eng_n;
        cli_ack_nxt    = cli_ack;
        cli_result_nxt = cli_result;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant_nxt = sel;
                    n_reg_nxt = operand[sel];
                    if (operand[sel] != '0) begin
                        eng_req_nxt = 1'b1;
                        eng_n_nxt   = operand[sel];
                        state_nxt   = ISSUE;
                    end else begin
                        cli_result_nxt   = '0;
                        cli_ack_nxt      = '0;
                        cli_ack_nxt[sel] = 1'b1;
                        state_nxt        = RELEASE;
                    end
                end
            end
            ISSUE: begin
                if (ack_rise) begin
                    eng_req_nxt = 1'b0;
                    state_nxt   = RELEASE;
                    cli_ack_nxt = '0;
                    // A client that walked away still lets the engine finish; its result is dropped.
                    if (cli_req[grant]) begin
                        cli_ack_nxt[grant] = 1'b1;
                        cli_result_nxt     = eng_result;
                    end
                end
            end
            RELEASE: begin
                if (cli_ack == '0 || !cli_req[grant]) begin
                    cli_ack_nxt    = '0;
                    cli_result_nxt = '0;
                    ptr_nxt        = grant_inc;
                    state_nxt      = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt      = IDLE;
                eng_req_nxt    = 1'b0;
                cli_ack_nxt    = '0;
                cli_result_nxt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            n_reg      <= '0;
            eng_req    <= 1'b0;
            eng_n      <= '0;
            eng_ack_d  <= 1'b0;
            cli_ack    <= '0;
            cli_result <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            grant      <= grant_nxt;
            n_reg      <= n_reg_nxt;
            eng_req    <= eng_req_nxt;
            eng_n      <= eng_n_nxt;
            eng_ack_d  <= eng_ack;
            cli_ack    <= cli_ack_nxt;
            cli_result <= cli_result_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/fib_arbiter.md
FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 Parameters SHALL be: NCLI, default 4, number of client ports; N_IN, default 7, operand width; N_OUT, default 90, result width.
REQ-002 Ports SHALL be:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cli_req  in  NCLI  per-client request level.
- cli_n  in  NCLI*N_IN  client operands; client i occupies bits [i*N_IN +: N_IN].
- cli_ack  out  NCLI  one-hot completion acknowledge.
- cli_result  out  N_OUT  result for the acked client.
- eng_req  out  1  request to the shared Fibonacci engine.
- eng_n  out  N_IN  operand to the engine.
- eng_ack  in  1  engine acknowledge; level, stays high until the engine accepts its next request.
- eng_result  in  N_OUT  engine result, valid while eng_ack is high.
- busy  out  1  high in every state except IDLE.
- grant  out  clog2(NCLI)  index of the client being served.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, RELEASE, GAP.
REQ-005 IDLE: if any cli_req bit is high, the FSM SHALL select a client round-robin, starting at pointer ptr and wrapping at NCLI-1 -> 0, and latch grant and its cli_n slice into n_reg on the same edge.
REQ-006 IDLE, selected operand nonzero: the FSM SHALL go to ISSUE with eng_req=1 and eng_n=n_reg.
REQ-007 IDLE, selected operand zero: the FSM SHALL not touch the engine; it SHALL set cli_result=0 and cli_ack[grant]=1, then go to RELEASE.
REQ-008 ISSUE: eng_req SHALL stay high until a rising edge of eng_ack, detected against a registered copy eng_ack_d; a level-high eng_ack left over from a prior transaction SHALL NOT count as completion.
REQ-009 ISSUE, on the detected edge: the arbiter SHALL capture eng_result into cli_result, drop eng_req, and go to RELEASE; it SHALL set cli_ack[grant]=1 only if cli_req[grant] is still high.
REQ-010 RELEASE: cli_ack[grant] and cli_result SHALL hold until cli_req[grant] is low.
REQ-011 RELEASE exit: on that edge cli_ack SHALL clear, ptr SHALL become grant+1 (mod NCLI), and the FSM SHALL go to GAP.
REQ-012 RELEASE entered without ack asserted (REQ-009 abandon case): the FSM SHALL go to GAP on the next edge.
REQ-013 GAP SHALL last exactly one cycle with eng_req=0, then return to IDLE, so the engine sees eng_req low for at least two cycles between transactions.
REQ-014 At most one cli_ack bit SHALL be high at any time, and never outside RELEASE.
REQ-015 A client that drops cli_req before being selected SHALL NOT be granted.
REQ-016 A client whose cli_req drops during ISSUE SHALL have the engine transaction completed and its result discarded, with no ack.
REQ-017 New client requests arriving during ISSUE, RELEASE or GAP SHALL wait; they are not lost as long as they stay high.
REQ-018 cli_result SHALL be 0 whenever cli_ack is all zero.
REQ-019 Service latency is engine latency plus 3 cycles of arbiter overhead: select, ack register, GAP.
REQ-020 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-021 While rst_n is low: state=IDLE, ptr=0, grant=0, n_reg=0, eng_req=0, eng_n=0, cli_ack=0, cli_result=0, busy=0, eng_ack_d=0.
REQ-022 Reset asserted mid-transaction SHALL abort immediately to the REQ-021 values, with no ack issued afterwards; the engine is reset by the same rst_n.

Verification
REQ-023 Single client 0, n=10 -> eng_n=10, cli_ack=4'b0001, cli_result=55; after cli_req[0] drops, cli_ack=0 next cycle and busy=0 two cycles later.
REQ-024 cli_req=4'b1111 held, all n=5, each client dropping its request after its ack -> grant order 0,1,2,3; all results 5; then cli_req[0] reasserted -> granted.
REQ-025 Client 2, n=0 -> eng_req never asserts, cli_ack=4'b0100 within 2 cycles, cli_result=0.
REQ-026 Client 1, n=1, with eng_ack still high from a previous transaction -> no completion until eng_ack falls and rises again; cli_result=1.
REQ-027 Client 3 drops cli_req during ISSUE -> engine completes, cli_ack stays 0, pending client 0 is served next.
REQ-028 rst_n pulsed low mid-ISSUE -> all outputs at REQ-021 values on the same cycle; a fresh client 0, n=7 request completes with result 13.
